// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage with a 2-entry skid buffer.
// The main register drives wb_*. The skid register catches one beat when write-back stalls.
// mem_ready depends only on the skid valid register, so wb_ready has no combinational path to MEM.
// Also counts retired beats.
module mem_wb_pipe #(
  parameter int unsigned DATA_W            = 32,
  parameter int unsigned ADDR_W            = 5,
  parameter int unsigned WE_W              = 4,
  parameter int unsigned PC_W              = 32,
  parameter int unsigned OP_W              = 8,
  parameter logic [PC_W-1:0] RESET_PC      = 32'hBFC0_0000,
  parameter int unsigned CNT_W             = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [WE_W-1:0]   mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [PC_W-1:0]   mem_pc,
  input  logic [OP_W-1:0]   mem_aluop,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_wd,
  output logic [WE_W-1:0]   wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [PC_W-1:0]   wb_pc,
  output logic [OP_W-1:0]   wb_aluop,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic [WE_W-1:0]   wreg;
    logic [DATA_W-1:0] wdata;
    logic [PC_W-1:0]   pc;
    logic [OP_W-1:0]   aluop;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } beat_t;

  // Beat value loaded by reset: all fields zero except the PC.
  function automatic beat_t reset_beat();
    beat_t b;
    b    = '0;
    b.pc = RESET_PC;
    return b;
  endfunction

  beat_t            in_s;
  beat_t            main_q, main_d;
  beat_t            skid_q, skid_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_s, ret_s;

  assign in_s = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata, pc: mem_pc,
                  aluop: mem_aluop, whilo: mem_whilo, hi: mem_hi, lo: mem_lo};

  assign acc_s = mem_valid & ~skid_v_q;
  assign ret_s = main_v_q & wb_ready;

  // Next-state logic. Flush overrides every transition, but a beat retired on the same edge is still counted.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    cnt_d    = ret_s ? (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      case ({main_v_q, skid_v_q})
        2'b00: begin
          if (acc_s) begin
            main_d   = in_s;
            main_v_d = 1'b1;
          end else begin
            main_v_d = 1'b0;
          end
        end
        2'b10: begin
          if (acc_s && !ret_s) begin
            skid_d   = in_s;
            skid_v_d = 1'b1;
          end else if (acc_s && ret_s) begin
            main_d = in_s;
          end else if (ret_s) begin
            main_v_d = 1'b0;
          end else begin
            main_v_d = 1'b1;
          end
        end
        2'b11: begin
          if (ret_s) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
          end else begin
            skid_v_d = 1'b1;
          end
        end
        default: begin
          // Skid valid without main valid cannot occur. Recover to EMPTY.
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q   <= reset_beat();
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_ready  = ~skid_v_q;
  assign wb_valid   = main_v_q;
  assign wb_wd      = main_q.wd;
  assign wb_wreg    = main_v_q ? main_q.wreg : {WE_W{1'b0}};
  assign wb_wdata   = main_q.wdata;
  assign wb_pc      = main_q.pc;
  assign wb_aluop   = main_q.aluop;
  assign wb_whilo   = main_v_q & main_q.whilo;
  assign wb_hi      = main_q.hi;
  assign wb_lo      = main_q.lo;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Randomised and directed bench for mem_wb_pipe.
// The reference model is a bounded queue of up to two beats plus a retire counter.
// The counter width is reduced to 8 so that wrap-around is reachable.
module tb_mem_wb_pipe;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned WW = 4;
  localparam int unsigned PW = 32;
  localparam int unsigned OW = 8;
  localparam int unsigned CW = 8;
  localparam logic [PW-1:0] RPC = 32'hBFC0_0000;

  typedef struct packed {
    logic [AW-1:0] wd;
    logic [WW-1:0] wreg;
    logic [DW-1:0] wdata;
    logic [PW-1:0] pc;
    logic [OW-1:0] aluop;
    logic          whilo;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_valid = 1'b0;
  logic flush = 1'b0;
  logic wb_ready = 1'b0;
  beat_t in_b = '0;

  logic          mem_ready, wb_valid, wb_whilo;
  logic [AW-1:0] wb_wd;
  logic [WW-1:0] wb_wreg;
  logic [DW-1:0] wb_wdata, wb_hi, wb_lo;
  logic [PW-1:0] wb_pc;
  logic [OW-1:0] wb_aluop;
  logic [CW-1:0] retire_cnt;

  mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .WE_W(WW), .PC_W(PW), .OP_W(OW),
                .RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wd(in_b.wd), .mem_wreg(in_b.wreg), .mem_wdata(in_b.wdata), .mem_pc(in_b.pc),
    .mem_aluop(in_b.aluop), .mem_whilo(in_b.whilo), .mem_hi(in_b.hi), .mem_lo(in_b.lo),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_pc(wb_pc),
    .wb_aluop(wb_aluop), .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.wd    = AW'($urandom);
    b.wreg  = WW'($urandom);
    b.wdata = $urandom;
    b.pc    = $urandom;
    b.aluop = OW'($urandom);
    b.whilo = 1'($urandom);
    b.hi    = $urandom;
    b.lo    = $urandom;
    return b;
  endfunction

  // Reference model. It holds a FIFO of at most two beats and the retire count.
  // It also remembers the most recent beat that was at the head of the FIFO.
  beat_t mq[$];
  beat_t last_head;
  logic [CW-1:0] mcnt;
  bit model_on = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      mcnt = '0;
      last_head = '0;
      last_head.pc = RPC;
      model_on = 1'b1;
    end else if (model_on) begin
      bit ret, acc;
      ret = (mq.size() > 0) && wb_ready;
      acc = mem_valid && (mq.size() < 2);
      if (ret) mcnt = mcnt + 8'd1;
      if (flush) mq.delete();
      else begin
        if (ret) void'(mq.pop_front());
        if (acc) mq.push_back(in_b);
      end
      if (mq.size() > 0) last_head = mq[0];
    end
  end

  // Compare process: on every falling edge, check each DUT output against the model.
  always @(negedge clk) begin
    if (model_on) begin
      bit v;
      v = mq.size() > 0;
      chk("wb_valid", 64'(wb_valid), 64'(v));
      chk("mem_ready", 64'(mem_ready), 64'(mq.size() < 2));
      chk("wb_wreg", 64'(wb_wreg), v ? 64'(last_head.wreg) : 64'd0);
      chk("wb_whilo", 64'(wb_whilo), v ? 64'(last_head.whilo) : 64'd0);
      chk("wb_wd", 64'(wb_wd), 64'(last_head.wd));
      chk("wb_wdata", 64'(wb_wdata), 64'(last_head.wdata));
      chk("wb_pc", 64'(wb_pc), 64'(last_head.pc));
      chk("wb_aluop", 64'(wb_aluop), 64'(last_head.aluop));
      chk("wb_hi", 64'(wb_hi), 64'(last_head.hi));
      chk("wb_lo", 64'(wb_lo), 64'(last_head.lo));
      chk("retire_cnt", 64'(retire_cnt), 64'(mcnt));
    end
  end

  // Advance one cycle. Return just after the falling edge, when outputs have settled and the compare has run.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_valid = 1'b0;
    flush = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Stream n beats back-to-back with wb_ready high, then drain the last beat.
  task automatic stream(input int n, input logic [CW-1:0] exp_cnt);
    int vcnt;
    vcnt = 0;
    do_reset();
    wb_ready = 1'b1;
    mem_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_b = rand_beat();
      step();
      if (wb_valid) vcnt++;
    end
    mem_valid = 1'b0;
    step();
    chk("stream_no_bubble", 64'(vcnt), 64'(n));
    chk("stream_cnt", 64'(retire_cnt), 64'(exp_cnt));
    chk("stream_drained", 64'(wb_valid), 64'd0);
  endtask

  initial begin
    beat_t b1, b2, b3;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;

    // Reset state
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_pc", 64'(wb_pc), 64'hBFC0_0000);
    chk("rst_wreg", 64'(wb_wreg), 64'd0);
    chk("rst_ready", 64'(mem_ready), 64'd1);
    chk("rst_cnt", 64'(retire_cnt), 64'd0);

    // Single beat with a one-cycle latency
    in_b = '0;
    in_b.wd = 5'd5;
    in_b.wreg = 4'hF;
    in_b.wdata = 32'h1234_5678;
    in_b.pc = 32'hBFC0_0004;
    mem_valid = 1'b1;
    wb_ready = 1'b1;
    step();
    mem_valid = 1'b0;
    chk("t1_valid", 64'(wb_valid), 64'd1);
    chk("t1_wd", 64'(wb_wd), 64'd5);
    chk("t1_wreg", 64'(wb_wreg), 64'hF);
    chk("t1_wdata", 64'(wb_wdata), 64'h1234_5678);
    chk("t1_pc", 64'(wb_pc), 64'hBFC0_0004);
    step();
    chk("t1_cnt", 64'(retire_cnt), 64'd1);
    chk("t1_idle_valid", 64'(wb_valid), 64'd0);
    chk("t1_idle_wreg", 64'(wb_wreg), 64'd0);

    // Back-pressure: fill the skid buffer, then drain in order
    do_reset();
    b1 = rand_beat(); b2 = rand_beat(); b3 = rand_beat();
    wb_ready = 1'b0;
    mem_valid = 1'b1;
    in_b = b1; step();
    in_b = b2; step();
    in_b = b3;
    chk("bp_ready_low", 64'(mem_ready), 64'd0);
    chk("bp_head1", 64'(wb_wdata), 64'(b1.wdata));
    step();
    chk("bp_hold1", 64'(wb_wdata), 64'(b1.wdata));
    chk("bp_still_full", 64'(mem_ready), 64'd0);
    wb_ready = 1'b1;
    step();
    chk("bp_out2", 64'(wb_wdata), 64'(b2.wdata));
    step();
    mem_valid = 1'b0;
    chk("bp_out3", 64'(wb_wdata), 64'(b3.wdata));
    chk("bp_out3_valid", 64'(wb_valid), 64'd1);
    step();
    chk("bp_cnt", 64'(retire_cnt), 64'd3);

    // Full throughput over 100 beats
    stream(100, 8'd100);

    // Flush while full, with a retire and an offered beat on the same edge
    do_reset();
    b1 = rand_beat(); b2 = rand_beat(); b3 = rand_beat();
    b1.wreg = 4'hF;
    wb_ready = 1'b0;
    mem_valid = 1'b1;
    in_b = b1; step();
    in_b = b2; step();
    in_b = b3;
    wb_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    mem_valid = 1'b0;
    chk("fl_cnt", 64'(retire_cnt), 64'd1);
    chk("fl_valid", 64'(wb_valid), 64'd0);
    chk("fl_wreg", 64'(wb_wreg), 64'd0);
    chk("fl_ready", 64'(mem_ready), 64'd1);
    chk("fl_hold_data", 64'(wb_wdata), 64'(b1.wdata));
    step();
    chk("fl_dropped", 64'(wb_valid), 64'd0);
    chk("fl_cnt2", 64'(retire_cnt), 64'd1);

    // HI/LO write for exactly one handshake
    do_reset();
    in_b = rand_beat();
    in_b.whilo = 1'b1;
    in_b.hi = 32'hAAAA_0000;
    in_b.lo = 32'h0000_5555;
    mem_valid = 1'b1;
    wb_ready = 1'b1;
    step();
    mem_valid = 1'b0;
    chk("hl_whilo", 64'(wb_whilo), 64'd1);
    chk("hl_hi", 64'(wb_hi), 64'hAAAA_0000);
    chk("hl_lo", 64'(wb_lo), 64'h0000_5555);
    step();
    chk("hl_whilo_off", 64'(wb_whilo), 64'd0);
    chk("hl_cnt", 64'(retire_cnt), 64'd1);

    // Reset while full
    do_reset();
    wb_ready = 1'b0;
    mem_valid = 1'b1;
    in_b = rand_beat(); step();
    in_b = rand_beat(); step();
    mem_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rf_valid", 64'(wb_valid), 64'd0);
    chk("rf_pc", 64'(wb_pc), 64'hBFC0_0000);
    chk("rf_cnt", 64'(retire_cnt), 64'd0);
    chk("rf_ready", 64'(mem_ready), 64'd1);

    // Counter wrap: 256 retires on an 8-bit counter wrap to zero
    stream(255, 8'd255);
    wb_ready = 1'b1;
    mem_valid = 1'b1;
    in_b = rand_beat();
    step();
    mem_valid = 1'b0;
    step();
    chk("wrap_cnt", 64'(retire_cnt), 64'd0);

    // Random traffic checked by the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_b = rand_beat();
      mem_valid = ($urandom_range(0, 9) < 7);
      wb_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 99) != 0);
      step();
    end
    rst = 1'b1;
    flush = 1'b0;
    mem_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer, so the write-back side can back-pressure without a combinational ready path into MEM.
- Carries the GPR write (per-byte enables), PC, ALU op and a HI/LO write channel.
- Supports synchronous flush and keeps a retired-instruction counter.
- Sits between the MEM stage and the register file / HI-LO unit.

Parameters:
- DATA_W, 32, GPR/HI/LO data width
- ADDR_W, 5, register address width
- WE_W, 4, byte write-enable width (DATA_W/8)
- PC_W, 32, PC width
- OP_W, 8, ALU op width
- RESET_PC, 32'hBFC0_0000, wb_pc value after reset
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- mem_valid  in  1  MEM beat valid
- mem_ready  out  1  stage can accept a beat
- mem_wd  in  ADDR_W  destination register
- mem_wreg  in  WE_W  byte write enables
- mem_wdata  in  DATA_W  write data
- mem_pc  in  PC_W  instruction PC
- mem_aluop  in  OP_W  ALU op
- mem_whilo  in  1  HI/LO write enable
- mem_hi  in  DATA_W  HI data
- mem_lo  in  DATA_W  LO data
- flush  in  1  discard all held beats
- wb_valid  out  1  output beat valid
- wb_ready  in  1  write-back consumes beat
- wb_wd  out  ADDR_W
- wb_wreg  out  WE_W  forced 0 when !wb_valid
- wb_wdata  out  DATA_W
- wb_pc  out  PC_W
- wb_aluop  out  OP_W
- wb_whilo  out  1  forced 0 when !wb_valid
- wb_hi  out  DATA_W
- wb_lo  out  DATA_W
- retire_cnt  out  CNT_W  count of completed output handshakes

Behaviour:
- Reset (rst==0 at posedge clk):
  - main and skid valid bits cleared; all wb_* data outputs 0; wb_pc=RESET_PC; retire_cnt=0.
  - mem_ready=1 from the first cycle after reset.
  - Reset mid-operation drops held beats without counting them.
- Storage: main register (drives wb_*) and skid register, each with a valid bit.
- States:
  - EMPTY: neither valid.
  - ONE: main valid only.
  - TWO: main and skid valid.
- Handshakes: acc = mem_valid & mem_ready; ret = wb_valid & wb_ready.
- mem_ready = !skid_valid, taken directly from a register with no combinational path from wb_ready. wb_valid = main_valid.
- Transitions, no flush:
  - EMPTY + acc -> ONE; main <= input.
  - ONE + acc & !ret -> TWO; skid <= input.
  - ONE + acc & ret -> ONE; main <= input.
  - ONE + !acc & ret -> EMPTY.
  - TWO + ret -> ONE; main <= skid. No accept is possible in TWO.
  - All other cases hold.
- Latency: a beat accepted at edge N is visible on wb_* after edge N; 1 cycle minimum.
- Full throughput with wb_ready held high. Beat order is strictly preserved.
- Flush at an edge:
  - Both valid bits cleared; state -> EMPTY.
  - A beat offered on the same edge is discarded, even if acc=1.
  - A ret on the same edge still counts, since the write-back already consumed it.
  - Flush has priority over all transitions; reset has priority over flush.
- wb_wreg and wb_whilo are gated to 0 whenever wb_valid=0. Other wb_* data fields hold their last value.
- retire_cnt increments by 1 on each ret and wraps modulo 2^CNT_W.
- HI/LO and GPR fields travel as one beat. No partial update.

Test Plan:
- Reset, then mem_valid=1, wd=5, wreg=4'hF, wdata=32'h1234_5678, pc=32'hBFC0_0004, wb_ready=1 -> next cycle wb_valid=1 with those values, retire_cnt=1 after the following edge; before the first beat wb_pc=32'hBFC0_0000, wb_wreg=0.
- Stream 3 beats with wb_ready=0 -> first beat held on wb_*, second in skid, mem_ready=0 after 2 accepts, third not accepted. Raise wb_ready -> outputs emerge in order 1,2,3 on consecutive cycles, retire_cnt=3.
- Continuous mem_valid and wb_ready=1 for 100 beats -> one output per cycle, no bubbles, retire_cnt=100.
- State TWO with wb_ready=1 and flush=1 on the same edge -> retire_cnt +1, wb_valid=0, wb_wreg=0, mem_ready=1; concurrent input beat dropped.
- mem_whilo=1, hi=32'hAAAA_0000, lo=32'h0000_5555 -> wb_whilo=1 with matching hi/lo for exactly one handshake, then 0.
- rst=0 asserted while in TWO -> next cycle EMPTY, wb_pc=RESET_PC, retire_cnt=0; preset retire_cnt=2^CNT_W-1 then one ret -> wraps to 0.
